// File: rtl/credential_entry.sv
// Credential entry buffer: collects up to eight keypad digits (four username
// nibbles followed by four password nibbles), supports backspace/clear, and
// discards a partial entry after TIMEOUT_CYCLES idle cycles.
module credential_entry #(
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       backspace,
  input  logic       clear,
  input  logic       resetCount,
  output logic [3:0] userNameInput0,
  output logic [3:0] userNameInput1,
  output logic [3:0] userNameInput2,
  output logic [3:0] userNameInput3,
  output logic [3:0] passwordInput0,
  output logic [3:0] passwordInput1,
  output logic [3:0] passwordInput2,
  output logic [3:0] passwordInput3,
  output logic [3:0] inputCount,
  output logic [1:0] phase,
  output logic       overflow,
  output logic       timeout
);

  typedef enum logic [1:0] {
    PH_EMPTY = 2'd0,
    PH_USER  = 2'd1,
    PH_PASS  = 2'd2,
    PH_FULL  = 2'd3
  } phase_t;

  localparam int                IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        MAX_COUNT = 4'd8;

  // Slots are held in entry order: slot 0 is the first digit typed.
  logic [3:0]        slot_q [8];
  logic [3:0]        slot_d [8];
  logic [3:0]        count_q, count_d;
  phase_t            phase_q, phase_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;

  logic              expire;
  logic              bs_accept;
  logic [2:0]        last_idx;

  function automatic phase_t phase_of(input logic [3:0] n);
    if (n == 4'd0)      return PH_EMPTY;
    else if (n <= 4'd4) return PH_USER;
    else if (n <= 4'd7) return PH_PASS;
    else                return PH_FULL;
  endfunction

  assign expire    = (count_q != 4'd0) && (idle_q == IDLE_LAST);
  assign bs_accept = backspace && (count_q != 4'd0);
  // Wraps to 7 when the count is 8, which is exactly the last full slot.
  assign last_idx  = count_q[2:0] - 3'd1;

  // Next-state: apply the single highest-priority event of this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    slot_d  = slot_q;
    count_d = count_q;
    idle_d  = (count_q == 4'd0) ? '0 : idle_q + IDLE_W'(1);
    ovf_d   = 1'b0;
    tmo_d   = 1'b0;

    if (resetCount || clear) begin
      for (int i = 0; i < 8; i++) slot_d[i] = 4'd0;
      count_d = 4'd0;
      idle_d  = '0;
    end else if (expire) begin
      for (int i = 0; i < 8; i++) slot_d[i] = 4'd0;
      count_d = 4'd0;
      idle_d  = '0;
      tmo_d   = 1'b1;
    end else if (bs_accept) begin
      slot_d[last_idx] = 4'd0;
      count_d          = count_q - 4'd1;
      idle_d           = '0;
    end else if (digit_valid) begin
      if (count_q == MAX_COUNT) begin
        // Rejected digit is not activity: the idle counter keeps running.
        ovf_d = 1'b1;
      end else begin
        slot_d[count_q[2:0]] = digit;
        count_d              = count_q + 4'd1;
        idle_d               = '0;
      end
    end

    phase_d = phase_of(count_d);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      // NOTE: the slot array is reset because its contents are visible outputs.
      for (int i = 0; i < 8; i++) slot_q[i] <= 4'd0;
      count_q <= 4'd0;
      phase_q <= PH_EMPTY;
      idle_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) slot_q[i] <= slot_d[i];
      count_q <= count_d;
      phase_q <= phase_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign userNameInput3 = slot_q[0];
  assign userNameInput2 = slot_q[1];
  assign userNameInput1 = slot_q[2];
  assign userNameInput0 = slot_q[3];
  assign passwordInput3 = slot_q[4];
  assign passwordInput2 = slot_q[5];
  assign passwordInput1 = slot_q[6];
  assign passwordInput0 = slot_q[7];
  assign inputCount     = count_q;
  assign phase          = phase_q;
  assign overflow       = ovf_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_credential_entry.sv
// Self-checking bench for credential_entry: directed scenarios plus random
// stimulus, all compared against a queue-based reference model.
module tb_credential_entry;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst, digit_valid, backspace, clear, resetCount;
  logic [3:0] digit;
  logic [3:0] un0, un1, un2, un3, pw0, pw1, pw2, pw3, input_count;
  logic [1:0] phase;
  logic       overflow, timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state: digits in entry order, and edge index of last activity.
  logic [3:0] mq[$];
  int         cyc = 0;
  int         last_act = 0;
  logic       exp_ovf = 1'b0;
  logic       exp_tmo = 1'b0;

  credential_entry #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .digit          (digit),
    .digit_valid    (digit_valid),
    .backspace      (backspace),
    .clear          (clear),
    .resetCount     (resetCount),
    .userNameInput0 (un0),
    .userNameInput1 (un1),
    .userNameInput2 (un2),
    .userNameInput3 (un3),
    .passwordInput0 (pw0),
    .passwordInput1 (pw1),
    .passwordInput2 (pw2),
    .passwordInput3 (pw3),
    .inputCount     (input_count),
    .phase          (phase),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] mslot(input int k);
    return (k < mq.size()) ? mq[k] : 4'd0;
  endfunction

  function automatic logic [1:0] mphase();
    int n = mq.size();
    if (n == 0) return 2'd0;
    if (n <= 4) return 2'd1;
    if (n <= 7) return 2'd2;
    return 2'd3;
  endfunction

  // Model of one clock edge, written from the behavioural rules.
  task automatic model_edge(input logic r, dv, input logic [3:0] d, input logic bs, cl, rc);
    cyc++;
    exp_ovf = 1'b0;
    exp_tmo = 1'b0;
    if (r) begin
      mq.delete();
    end else if (rc || cl) begin
      mq.delete();
    end else if (mq.size() > 0 && (cyc - last_act) == TMO) begin
      mq.delete();
      exp_tmo = 1'b1;
    end else if (bs && mq.size() > 0) begin
      void'(mq.pop_back());
      last_act = cyc;
    end else if (dv) begin
      if (mq.size() == 8) exp_ovf = 1'b1;
      else begin
        mq.push_back(d);
        last_act = cyc;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".un3"},   32'(un3), 32'(mslot(0)));
    check({tag, ".un2"},   32'(un2), 32'(mslot(1)));
    check({tag, ".un1"},   32'(un1), 32'(mslot(2)));
    check({tag, ".un0"},   32'(un0), 32'(mslot(3)));
    check({tag, ".pw3"},   32'(pw3), 32'(mslot(4)));
    check({tag, ".pw2"},   32'(pw2), 32'(mslot(5)));
    check({tag, ".pw1"},   32'(pw1), 32'(mslot(6)));
    check({tag, ".pw0"},   32'(pw0), 32'(mslot(7)));
    check({tag, ".count"}, 32'(input_count), 32'(mq.size()));
    check({tag, ".phase"}, 32'(phase), 32'(mphase()));
    check({tag, ".ovf"},   32'(overflow), 32'(exp_ovf));
    check({tag, ".tmo"},   32'(timeout), 32'(exp_tmo));
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare after the edge.
  task automatic step(input string tag, input logic r, dv, input logic [3:0] d,
                      input logic bs, cl, rc);
    rst = r; digit_valid = dv; digit = d; backspace = bs; clear = cl; resetCount = rc;
    @(posedge clk);
    model_edge(r, dv, d, bs, cl, rc);
    #1;
    compare_all(tag);
  endtask

  task automatic key(input string tag, input logic [3:0] d);
    step(tag, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] pat [8];
    pat = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};

    // Reset state
    step("reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step("reset2", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("reset_count", 32'(input_count), 32'd0);

    // Full entry with pattern 1,1,0,0,1,1,0,0
    for (int i = 0; i < 8; i++) key("fill", pat[i]);
    check("full_phase", 32'(phase), 32'd3);
    check("full_count", 32'(input_count), 32'd8);
    check("full_un3", 32'(un3), 32'd1);
    check("full_pw0", 32'(pw0), 32'd0);

    // Overflow: one-cycle pulse, contents unchanged
    key("ovf", 4'd5);
    check("ovf_pulse", 32'(overflow), 32'd1);
    idle("ovf_after");
    check("ovf_gone", 32'(overflow), 32'd0);
    check("ovf_count", 32'(input_count), 32'd8);

    // resetCount together with digit_valid
    step("rc_dv", 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    check("rc_count", 32'(input_count), 32'd0);

    // Backspace sequence
    key("bs", 4'd3); key("bs", 4'd7); key("bs", 4'd9);
    step("bs1", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("bs1_count", 32'(input_count), 32'd2);
    check("bs1_un1", 32'(un1), 32'd0);
    check("bs1_phase", 32'(phase), 32'd1);
    step("bs2", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step("bs3", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("bs3_count", 32'(input_count), 32'd0);
    step("bs_empty", 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);   // backspace not accepted: digit lands
    step("bs_drop", 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);    // backspace accepted: digit dropped
    check("bs_drop_count", 32'(input_count), 32'd0);

    // Timeout after 16 idle cycles
    key("tmo", 4'd2); key("tmo", 4'd8);
    for (int i = 1; i <= TMO; i++) begin
      idle("tmo_idle");
      if (i == TMO - 1) check("tmo_early", 32'(timeout), 32'd0);
    end
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_count", 32'(input_count), 32'd0);
    for (int i = 0; i < 20; i++) idle("tmo_quiet");
    check("tmo_quiet", 32'(timeout), 32'd0);

    // Full entry times out too; digit at expiry gives timeout, not overflow
    for (int i = 0; i < 8; i++) key("ftmo", 4'(i + 3));
    for (int i = 0; i < TMO - 1; i++) idle("ftmo_idle");
    key("ftmo_exp", 4'd1);
    check("ftmo_pulse", 32'(timeout), 32'd1);
    check("ftmo_noovf", 32'(overflow), 32'd0);

    // rst with clear and digit_valid mid-entry
    for (int i = 0; i < 5; i++) key("rst_mid", 4'(15 - i));
    step("rst_mid", 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    check("rst_mid_count", 32'(input_count), 32'd0);
    check("rst_mid_pw3", 32'(pw3), 32'd0);

    // Random traffic, with occasional long idle gaps to reach expiry
    for (int n = 0; n < 3000; n++) begin
      logic r, dv, bs, cl, rc;
      r  = ($urandom_range(0, 199) == 0);
      dv = ($urandom_range(0, 99) < 45);
      bs = ($urandom_range(0, 99) < 12);
      cl = ($urandom_range(0, 99) < 3);
      rc = ($urandom_range(0, 99) < 3);
      step("rand", r, dv, 4'($urandom_range(0, 15)), bs, cl, rc);
      if ($urandom_range(0, 99) < 4) begin
        int gap = $urandom_range(TMO - 2, TMO + 2);
        for (int g = 0; g < gap; g++) idle("rand_gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
